// File: rtl/qif_pkg.sv
// rtl/qif_pkg.sv - shared QIF types, default widths and saturation helpers
package qif_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECAY,
        ACCUM,
        OUTPUT
    } syn_state_t;

    localparam int QIF_W     = 8;
    localparam int QIF_ACC_W = 12;

    // Clamp an integer into the signed range of a bits-wide two's complement value.
    function automatic int clamp_int(input int value, input int bits);
        int lo;
        int hi;
        lo = -(1 << (bits - 1));
        hi = (1 << (bits - 1)) - 1;
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/qif_synapse_if.sv
// rtl/qif_synapse_if.sv - spike, weight-write and synaptic-current bundle of qif_synapse
interface qif_synapse_if #(
    parameter int N_IN = 4,
    parameter int W    = 8
);
    localparam int AW = $clog2(N_IN);

    logic                tick;
    logic [N_IN-1:0]     spike_in;
    logic                w_we;
    logic [AW-1:0]       w_addr;
    logic signed [W-1:0] w_data;
    logic signed [W-1:0] I_syn;
    logic                syn_valid;
    logic                busy;
    logic                tick_overrun;

    modport master (
        output tick, spike_in, w_we, w_addr, w_data,
        input  I_syn, syn_valid, busy, tick_overrun
    );

    modport slave (
        input  tick, spike_in, w_we, w_addr, w_data,
        output I_syn, syn_valid, busy, tick_overrun
    );

endinterface

// File: rtl/qif_sat_add.sv
// rtl/qif_sat_add.sv - signed saturating add of an ACC_W accumulator and a sign-extended W operand
module qif_sat_add import qif_pkg::*; #(
    parameter int ACC_W = QIF_ACC_W,
    parameter int W     = QIF_W
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W:0] wide;

    always_comb begin
        wide = {a[ACC_W-1], a} + {{(ACC_W + 1 - W){b[W-1]}}, b};
        // Top two bits disagreeing means the true sum left the ACC_W range.
        if (wide[ACC_W] != wide[ACC_W-1])
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = wide[ACC_W-1:0];
    end

endmodule

// File: rtl/qif_synapse.sv
// rtl/qif_synapse.sv - per-tick exponential-decay synapse producing saturated I_syn
// Optional macro QIF_SYN_LEAK_FLOOR_EN: small positive residue leaks by one per step.
module qif_synapse import qif_pkg::*; #(
    parameter int N_IN        = 4,
    parameter int W           = QIF_W,
    parameter int ACC_W       = QIF_ACC_W,
    parameter int DECAY_SHIFT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    qif_synapse_if.slave  bus
);

    localparam int IDX_W = $clog2(N_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    syn_state_t              state;
    syn_state_t              next_state;
    logic [N_IN-1:0]         spk_lat;
    logic [IDX_W-1:0]        idx;
    logic signed [W-1:0]     weights [N_IN];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_decay;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [W-1:0]     add_operand;
    logic                    accept;
    logic                    last_idx;

`ifdef QIF_SYN_LEAK_FLOOR_EN
    localparam logic signed [ACC_W-1:0] ZERO_ACC   = '0;
    localparam logic signed [ACC_W-1:0] ONE_ACC    = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] LEAK_LIMIT = ACC_W'(1 << DECAY_SHIFT);
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last_idx   = (idx == LAST_IDX);
        case (state)
            IDLE: begin
                if (bus.tick) begin
                    accept     = 1'b1;
                    next_state = DECAY;
                end
            end
            DECAY:   next_state = ACCUM;
            ACCUM:   if (last_idx) next_state = OUTPUT;
            OUTPUT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        acc_decay = acc - (acc >>> DECAY_SHIFT);
`ifdef QIF_SYN_LEAK_FLOOR_EN
        if (acc > ZERO_ACC && acc < LEAK_LIMIT)
            acc_decay = acc - ONE_ACC;
`endif
        add_operand = spk_lat[idx] ? weights[idx] : '0;
    end

    qif_sat_add #(
        .ACC_W (ACC_W),
        .W     (W)
    ) u_sat_add (
        .a   (acc),
        .b   (add_operand),
        .sum (acc_sum)
    );

    // I_syn is loaded on the last accumulate so it is already valid during OUTPUT.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc              <= '0;
            idx              <= '0;
            spk_lat          <= '0;
            bus.I_syn        <= '0;
            bus.tick_overrun <= 1'b0;
        end else begin
            if (state != IDLE && bus.tick)
                bus.tick_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        spk_lat <= bus.spike_in;
                        idx     <= '0;
                    end
                end
                DECAY: acc <= acc_decay;
                ACCUM: begin
                    acc <= acc_sum;
                    idx <= idx + IDX_W'(1);
                    if (last_idx)
                        bus.I_syn <= W'(clamp_int(int'(acc_sum), W));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < N_IN; i++)
                weights[i] <= '0;
        end else if (bus.w_we) begin
            weights[bus.w_addr] <= bus.w_data;
        end
    end

    assign bus.syn_valid = (state == OUTPUT);
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_qif_synapse.sv
// tb/tb_qif_synapse.sv - scoreboard bench for qif_synapse against a step-level model
module tb_qif_synapse;

    localparam int N_IN = 4;
    localparam int W    = 8;
    localparam int ACC_W = 12;
    localparam int DS   = 3;
    localparam int AW   = $clog2(N_IN);
    localparam int LAT  = N_IN + 2;
`ifdef QIF_SYN_LEAK_FLOOR_EN
    localparam bit LEAK = 1'b1;
`else
    localparam bit LEAK = 1'b0;
`endif

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    qif_synapse_if #(.N_IN(N_IN), .W(W)) syn_if ();

    qif_synapse #(
        .N_IN        (N_IN),
        .W           (W),
        .ACC_W       (ACC_W),
        .DECAY_SHIFT (DS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (syn_if)
    );

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   valid_seen = 0;
    exp_t exp_q[$];
    int   m_acc;
    int   m_w[N_IN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int floor_div(input int v, input int d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // One time step: exponential decay, then weighted spikes with saturation.
    function automatic int model_step(input logic [N_IN-1:0] spk);
        int step;
        step = 1 << DS;
        if (LEAK && m_acc > 0 && m_acc < step)
            m_acc = m_acc - 1;
        else
            m_acc = m_acc - floor_div(m_acc, step);
        for (int i = 0; i < N_IN; i++)
            if (spk[i]) m_acc = clampi(m_acc + m_w[i], -(1 << (ACC_W - 1)), (1 << (ACC_W - 1)) - 1);
        return clampi(m_acc, -(1 << (W - 1)), (1 << (W - 1)) - 1);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (syn_if.syn_valid === 1'b1) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    check("valid with empty queue", int'(syn_if.syn_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("I_syn", int'(syn_if.I_syn), e.val);
                    check("valid cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (syn_if.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check({name, " timeout"}, int'(syn_if.busy), 0);
    endtask

    task automatic write_w(input int addr, input int data);
        cyc_step();
        syn_if.w_we   = 1'b1;
        syn_if.w_addr = AW'(addr);
        syn_if.w_data = W'(data);
        cyc_step();
        syn_if.w_we = 1'b0;
        m_w[addr] = data;
    endtask

    task automatic do_tick(input logic [N_IN-1:0] spk);
        exp_t e;
        cyc_step();
        syn_if.tick     = 1'b1;
        syn_if.spike_in = spk;
        e.cyc = cyc + LAT;
        e.val = model_step(spk);
        exp_q.push_back(e);
        cyc_step();
        syn_if.tick     = 1'b0;
        syn_if.spike_in = N_IN'($urandom);
        check("busy after tick", int'(syn_if.busy), 1);
        wait_idle("step");
    endtask

    task automatic model_reset();
        m_acc = 0;
        for (int i = 0; i < N_IN; i++) m_w[i] = 0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        int   seen;
        syn_if.tick     = 1'b0;
        syn_if.spike_in = '0;
        syn_if.w_we     = 1'b0;
        syn_if.w_addr   = '0;
        syn_if.w_data   = '0;
        model_reset();

        rst_n = 1'b1;
        repeat (3) cyc_step();
        check("reset I_syn", int'(syn_if.I_syn), 0);
        check("reset syn_valid", int'(syn_if.syn_valid), 0);
        check("reset busy", int'(syn_if.busy), 0);
        check("reset tick_overrun", int'(syn_if.tick_overrun), 0);
        rst_n = 1'b0;

        // Build a nonzero state, then reset in the middle of ACCUM.
        write_w(0, 40);
        write_w(1, -7);
        do_tick(4'b0011);
        check("pre-abort I_syn", int'(syn_if.I_syn), 33);
        cyc_step();
        syn_if.tick     = 1'b1;
        syn_if.spike_in = 4'b1111;
        cyc_step();
        syn_if.tick = 1'b0;
        repeat (2) cyc_step();
        check("busy mid accum", int'(syn_if.busy), 1);
        seen  = valid_seen;
        rst_n = 1'b1;
        cyc_step();
        cyc_step();
        check("abort I_syn", int'(syn_if.I_syn), 0);
        check("abort busy", int'(syn_if.busy), 0);
        check("abort syn_valid", int'(syn_if.syn_valid), 0);
        rst_n = 1'b0;
        model_reset();
        repeat (8) cyc_step();
        check("no valid after abort", valid_seen, seen);
        do_tick(4'b1111);
        check("weights cleared", int'(syn_if.I_syn), 0);

        // Basic accumulate and decay.
        write_w(0, 10);
        write_w(1, 20);
        write_w(2, -5);
        write_w(3, 0);
        do_tick(4'b0011);
        check("step 30", int'(syn_if.I_syn), 30);
        do_tick(4'b0000);
        check("decay 27", int'(syn_if.I_syn), 27);
        do_tick(4'b0000);
        check("decay 24", int'(syn_if.I_syn), 24);
        do_tick(4'b0100);
        check("decay plus spike 16", int'(syn_if.I_syn), 16);

        // Saturation in both directions.
        for (int i = 0; i < N_IN; i++) write_w(i, 127);
        do_tick(4'b1111);
        check("clamp high", int'(syn_if.I_syn), 127);
        repeat (6) do_tick(4'b1111);
        check("no wrap high", int'(syn_if.I_syn), 127);
        for (int i = 0; i < N_IN; i++) write_w(i, -128);
        repeat (8) do_tick(4'b1111);
        check("clamp low", int'(syn_if.I_syn), -128);
        repeat (2) do_tick(4'b0000);

        // Tick during a step is ignored and flagged.
        check("overrun clear", int'(syn_if.tick_overrun), 0);
        cyc_step();
        syn_if.tick     = 1'b1;
        syn_if.spike_in = 4'b0011;
        e.cyc = cyc + LAT;
        e.val = model_step(4'b0011);
        exp_q.push_back(e);
        cyc_step();
        syn_if.tick = 1'b0;
        cyc_step();
        cyc_step();
        syn_if.tick = 1'b1;
        cyc_step();
        syn_if.tick = 1'b0;
        wait_idle("overrun step");
        check("overrun set", int'(syn_if.tick_overrun), 1);
        do_tick(4'b0000);
        check("overrun sticky", int'(syn_if.tick_overrun), 1);

        // Writes during ACCUM: same-cycle write sees old value, earlier write sees new.
        cyc_step();
        syn_if.tick     = 1'b1;
        syn_if.spike_in = 4'b1001;
        m_w[3] = 60;
        e.cyc = cyc + LAT;
        e.val = model_step(4'b1001);
        exp_q.push_back(e);
        cyc_step();
        syn_if.tick = 1'b0;
        cyc_step();
        syn_if.w_we   = 1'b1;
        syn_if.w_addr = AW'(0);
        syn_if.w_data = W'(50);
        cyc_step();
        syn_if.w_addr = AW'(3);
        syn_if.w_data = W'(60);
        cyc_step();
        syn_if.w_we = 1'b0;
        m_w[0] = 50;
        wait_idle("write step");
        do_tick(4'b1001);

        // Residual positive accumulator, with and without the leak floor.
        rst_n = 1'b1;
        cyc_step();
        rst_n = 1'b0;
        model_reset();
        check("overrun cleared by reset", int'(syn_if.tick_overrun), 0);
        write_w(0, 5);
        do_tick(4'b0001);
        check("residue 5", int'(syn_if.I_syn), 5);
        repeat (8) do_tick(4'b0000);
        check("residue after 8 steps", int'(syn_if.I_syn), LEAK ? 0 : 5);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1)
                write_w(int'($urandom_range(0, N_IN - 1)), int'($urandom_range(0, 255)) - 128);
            do_tick(N_IN'($urandom));
        end

        repeat (4) cyc_step();
        check("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
